lut_window_sequencer: RTL and testbench
=======================================

Name: lut_window_sequencer

Overview:
- Feeder/collector stage that sits directly in front of the 5-input single-output approximate LUT cell (EQ2 cell: inputs i4..i0, output o5).
- Accepts a DATA_W-bit operand over a valid/ready handshake.
- Presents one 5-bit sliding window of the operand to the LUT cell per clock and registers each o5 result into a result word.
- Returns the DATA_W-bit result word over a second valid/ready handshake. One LUT instance is time-multiplexed, trading latency for area and power.

Parameters:
- DATA_W, 16, operand and result width in bits; legal range 5..32.
- IDX_W, 5, width of the window index counter; must satisfy 2**IDX_W >= DATA_W.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand offered.
- in_ready  output  1  block can accept an operand.
- in_data  input  DATA_W  operand.
- lut_i  output  5  window to the LUT cell; lut_i[4] drives i4 and lut_i[0] drives i0.
- lut_o5  input  1  LUT cell output; combinational function of lut_i.
- out_valid  output  1  result word available.
- out_ready  input  1  consumer takes the result.
- out_data  output  DATA_W  result word.
- busy  output  1  high whenever the state is not IDLE.

Behaviour:
- Reset (async assert, sync deassert on clk):
  - State goes to IDLE.
  - Operand shift register, result register and index all go to 0.
  - Outputs: in_ready=1, out_valid=0, out_data=0, lut_i=0, busy=0.
- FSM states: IDLE, SCAN, DONE.
- IDLE:
  - in_ready=1, lut_i=0.
  - On an edge with in_valid&in_ready: opsr<=in_data, res<=0, idx<=0, state goes to SCAN.
  - in_data is ignored when in_valid=0.
- SCAN:
  - in_ready=0.
  - lut_i = opsr[4:0]. opsr is zero-filled from the MSB as it shifts, so window k covers operand bits k+4..k, with bits at index >= DATA_W read as 0.
  - Each edge: res[idx]<=lut_o5, opsr<=opsr>>1, idx<=idx+1.
  - On the edge where idx==DATA_W-1, that last bit is written and the state goes to DONE.
  - Exactly DATA_W SCAN cycles per operand.
- DONE:
  - out_valid=1, out_data=res, held stable until out_ready=1.
  - lut_i=0, in_ready=0.
  - On an edge with out_ready=1: state goes to IDLE; out_valid drops on that edge.
  - out_data keeps the last result until the next accept. It is not cleared on leaving DONE.
- Latency and throughput:
  - out_valid rises DATA_W cycles after the accepting edge.
  - Minimum initiation interval is DATA_W+2 cycles (accept, DATA_W scans, DONE with out_ready=1).
  - No overlap between operations; a new operand is refused (in_ready=0) until the state is back in IDLE.
- Boundary conditions:
  - out_ready asserted before out_valid: no effect. It is sampled only in DONE.
  - in_valid held high across DONE: no second accept until IDLE. Then one accept per IDLE visit.
  - Back-to-back: out_ready=1 in DONE gives IDLE on the next cycle, and an operand can be accepted there.
  - rst mid-SCAN or mid-DONE: the operation is abandoned and the result is lost. No out_valid pulse; all outputs take their reset values immediately (async).
  - lut_o5 is sampled only in SCAN; its value in other states is don't-care.
- Width rules: idx compares against the constant DATA_W-1 at IDX_W bits; no wrap-around occurs because DONE is entered first.

Test Plan:
- Bench stub for these checks: lut_o5 = parity of lut_i, DATA_W=16.
- Reset: rst pulsed mid-clock with no clock edge -> in_ready=1, out_valid=0, busy=0, lut_i=0 immediately.
- Operand 0x0001 -> out_valid rises exactly 16 cycles after accept; out_data=0x0001; lut_i observed = 0x01 then 0x00 for 15 cycles.
- Operand 0x0003 -> out_data=0x0002. Operand 0xFFFF -> out_data=0xAFFF; lut_i shows 0x1F for k=0..11, then 0x0F, 0x07, 0x03, 0x01.
- Backpressure: out_ready=0 for 10 cycles in DONE -> out_valid and out_data stable, in_ready=0 while in_valid=1. Releasing out_ready -> IDLE next cycle, second operand 0x0001 accepted, out_data=0x0001.
- Reset at SCAN cycle 7 of operand 0xFFFF -> no out_valid; the next operand 0x0003 gives out_data=0x0002, with no residue from the aborted run.

Source files
------------

// File: rtl/lut_window_sequencer.sv
// Time-multiplexed feeder/collector for a single 5-input LUT cell.
// Slides a 5-bit window across the operand and gathers one o5 bit per clock.
module lut_window_sequencer #(
    parameter int DATA_W = 16,
    parameter int IDX_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic [4:0]        lut_i,
    input  logic              lut_o5,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } state_t;

    localparam logic [IDX_W-1:0] LAST = IDX_W'(DATA_W - 1);

    state_t            state;
    state_t            state_nxt;
    logic [DATA_W-1:0] opsr;
    logic [DATA_W-1:0] res;
    logic [IDX_W-1:0]  idx;

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        lut_i     = '0;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = SCAN;
            end
            SCAN: begin
                lut_i = opsr[4:0];
                if (idx == LAST) state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // res is cleared on accept, so OR-ing each bit in is a plain write
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            opsr <= '0;
            res  <= '0;
            idx  <= '0;
        end else if (state == IDLE && in_valid) begin
            opsr <= in_data;
            res  <= '0;
            idx  <= '0;
        end else if (state == SCAN) begin
            res  <= res | (DATA_W'(lut_o5) << idx);
            opsr <= opsr >> 1;
            idx  <= idx + IDX_W'(1);
        end
    end

    assign out_data = res;
    assign busy     = (state != IDLE);

endmodule

// File: tb/tb_lut_window_sequencer.sv
// Randomised scoreboard bench for lut_window_sequencer with a parity LUT stub.
// Driver pushes expected words; a negedge monitor pops them on each output transfer.
module tb_lut_window_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_data = '0;
    logic [4:0]  lut_i;
    logic        lut_o5;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_data;
    logic        busy;

    int total = 0;
    int bad   = 0;
    logic [15:0] exp_q[$];

    always #5 clk = ~clk;

    assign lut_o5 = ^lut_i;

    lut_window_sequencer #(
        .DATA_W(16),
        .IDX_W (5)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .lut_i    (lut_i),
        .lut_o5   (lut_o5),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .busy     (busy)
    );

    // Bit k of the result is the parity of operand bits k+4..k.
    function automatic logic [15:0] model(input logic [15:0] x);
        logic [15:0] r;
        int unsigned xv;
        int unsigned w;
        r  = '0;
        xv = x;
        for (int k = 0; k < 16; k++) begin
            w    = (xv >> k) % 32;
            r[k] = ($countones(w) % 2) == 1;
        end
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_unexpected: got %0h want none", out_data);
            end else begin
                chk("out_data", out_data, exp_q.pop_front());
            end
        end
    end

    task automatic send(input logic [15:0] op, output int n);
        in_valid = 1'b1;
        in_data  = op;
        n = 0;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: got in_ready=0 want 1");
        end else begin
            exp_q.push_back(model(op));
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = 16'($urandom);
    endtask

    task automatic run_op(input logic [15:0] op, input int hold,
                          input bit early, input bit lutchk,
                          input bit b2b, input logic [15:0] nxt,
                          input bit imm);
        logic [4:0]  win[16];
        logic [15:0] d;
        int n;
        int cyc;
        send(op, n);
        if (imm) chk("b2b_accept_wait", n, 0);
        out_ready = early;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (!out_valid && cyc <= 16) win[cyc-1] = lut_i;
        end while (!out_valid && cyc < 100);
        chk("latency", cyc - 1, 16);
        if (lutchk) begin
            for (int k = 0; k < 16; k++)
                chk("lut_i", win[k], (32'(op) >> k) & 32'h1f);
        end
        if (b2b) begin
            in_valid = 1'b1;
            in_data  = nxt;
        end
        if (!early) begin
            d = out_data;
            for (int h = 0; h < hold; h++) begin
                @(negedge clk);
                chk("hold_valid", out_valid, 1);
                chk("hold_data", out_data, d);
                chk("hold_in_ready", in_ready, 0);
            end
            @(posedge clk);
            #1 out_ready = 1'b1;
        end
        @(posedge clk);
        #1 out_ready = 1'b0;
        chk("idle_in_ready", in_ready, 1);
        chk("idle_busy", busy, 0);
        chk("idle_valid", out_valid, 0);
        chk("idle_lut", lut_i, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int seen;
        bit prev_b2b;
        bit early;
        bit b2b;
        logic [15:0] nxt;
        logic [15:0] op;

        #2 rst = 1'b1;
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_lut", lut_i, 0);
        chk("rst_out_data", out_data, 0);
        @(negedge clk) rst = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 5; i++) begin
            in_data = 16'($urandom);
            @(posedge clk);
            #1;
        end
        chk("idle_ignore", busy, 0);

        run_op(16'h0001, 0, 1'b0, 1'b1, 1'b0, 16'h0, 1'b0);
        run_op(16'h0003, 0, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
        run_op(16'hFFFF, 2, 1'b0, 1'b1, 1'b0, 16'h0, 1'b0);
        run_op(16'h5A3C, 10, 1'b0, 1'b0, 1'b1, 16'h0001, 1'b0);
        run_op(16'h0001, 0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b1);

        send(16'hFFFF, n);
        repeat (6) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("abort_in_ready", in_ready, 1);
        chk("abort_out_valid", out_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_lut", lut_i, 0);
        chk("abort_out_data", out_data, 0);
        void'(exp_q.pop_back());
        @(negedge clk) rst = 1'b0;
        seen = 0;
        repeat (25) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("abort_no_valid", seen, 0);
        @(posedge clk);
        #1;
        run_op(16'h0003, 1, 1'b0, 1'b1, 1'b0, 16'h0, 1'b0);

        prev_b2b = 1'b0;
        nxt = 16'($urandom);
        for (int i = 0; i < 20; i++) begin
            op    = prev_b2b ? nxt : 16'($urandom);
            early = 1'($urandom_range(0, 1));
            b2b   = (i < 19) && ($urandom_range(0, 1) == 1);
            nxt   = 16'($urandom);
            run_op(op, $urandom_range(0, 3), early, 1'b1, b2b, nxt,
                   prev_b2b);
            prev_b2b = b2b;
        end

        repeat (3) @(negedge clk);
        chk("sb_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
